// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester arbitrated ALU controller.
// Contents: DATA_W default, opcode enum, FSM state enum.
package alu_arb_pkg;

  localparam int unsigned DATA_W_DEF = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_SHL = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_arb_ctrl_if.sv
// Request/response bundle between two requesters and alu_arb_ctrl.
// master: requester side (drives req_*, rsp_ready).
// slave : controller side (drives req_ready, rsp_*, busy, op_count).
interface alu_arb_ctrl_if
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);
  localparam int unsigned RES_W = DATA_W + 1;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  alu_op_e           req0_op;
  alu_op_e           req1_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic              busy;
  logic [7:0]        op_count;

  modport master (
    output req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, busy, op_count
  );

  modport slave (
    input  req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, busy, op_count
  );

endinterface

// File: rtl/alu3_core.sv
// Combinational ALU: ADD/SUB/XOR/SHL on DATA_W operands, DATA_W+1 result.
// Ports: op (opcode), a, b (operands) -> result (zero-extended / mod 2^RES_W).
module alu3_core
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   result
);
  localparam int unsigned RES_W = DATA_W + 1;

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = RES_W'(a) + RES_W'(b);
      OP_SUB:  result = RES_W'(a) - RES_W'(b);
      OP_XOR:  result = RES_W'(a ^ b);
      OP_SHL:  result = {a, 1'b0};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Two-requester arbitrated ALU controller: IDLE -> EXEC -> RESP handshake.
// Ports: clk, rst_n (async, active-low), bus (alu_arb_ctrl_if.slave).
// Build option: ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration,
// otherwise requester 0 has fixed priority.
module alu_arb_ctrl
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  alu_arb_ctrl_if.slave bus
);
  localparam int unsigned RES_W = DATA_W + 1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  alu_op_e           op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
  logic [7:0]        op_count_q, op_count_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        grant_c;
  logic [1:0]        req_ready_c;
  logic [RES_W-1:0]  alu_res_c;

  // ALU works only on the latched operation.
  alu3_core #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res_c)
  );

  // Arbitration winner, one-hot.
  always_comb begin
    grant_c = 2'b00;
    case (bus.req_valid)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      2'b11:   grant_c = last_grant_q ? 2'b01 : 2'b10;
`else
      2'b11:   grant_c = 2'b01;
`endif
      default: grant_c = 2'b00;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    op_count_d   = op_count_q;
    last_grant_d = last_grant_q;
    req_ready_c  = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst_n so req_ready drops the instant reset asserts.
        if (rst_n && (grant_c != 2'b00)) begin
          req_ready_c = grant_c;
          owner_d     = grant_c[1];
          op_d        = grant_c[1] ? bus.req1_op : bus.req0_op;
          a_d         = grant_c[1] ? bus.req1_a  : bus.req0_a;
          b_d         = grant_c[1] ? bus.req1_b  : bus.req0_b;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_res_c;
        rsp_valid_d  = owner_q ? 2'b10 : 2'b01;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d  = 2'b00;
          op_count_d   = op_count_q + 8'd1;
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      op_count_q   <= 8'd0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      op_count_q   <= op_count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Scoreboard bench for alu_arb_ctrl (DATA_W = 3).
module tb_alu_arb_ctrl;
  import alu_arb_pkg::*;

  localparam int unsigned DW = 3;
  localparam int unsigned RW = DW + 1;

  typedef struct packed {
    logic [1:0]    vld;
    logic [RW-1:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   mcnt = 0;
  exp_t exp_q[$];

  alu_arb_ctrl_if #(.DATA_W(DW)) bus ();

  alu_arb_ctrl #(.DATA_W(DW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] model(input alu_op_e op, input int a, input int b);
    int r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_XOR:  r = a ^ b;
      default: r = a * 2;
    endcase
    return RW'(r & ((1 << RW) - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.req0_op = alu_op_e'($urandom_range(0, 3));
    bus.req1_op = alu_op_e'($urandom_range(0, 3));
    bus.req0_a  = DW'($urandom);
    bus.req0_b  = DW'($urandom);
    bus.req1_a  = DW'($urandom);
    bus.req1_b  = DW'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    scramble();
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    repeat (2) tick();
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    mcnt = 0;
    exp_q.delete();
  endtask

  // Pop the oldest expected response and compare against the DUT outputs.
  task automatic pop_check(output exp_t e);
    e = '0;
    if (exp_q.size() == 0) begin
      check("rsp_unexpected", 32'(bus.rsp_valid), 0);
    end else begin
      e = exp_q.pop_front();
      check("rsp_valid", 32'(bus.rsp_valid), 32'(e.vld));
      check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
    end
  endtask

  task automatic do_op(input int r, input alu_op_e op, input int a, input int b, input bit hold);
    int   cyc;
    exp_t e;
    exp_t got;
    if (r == 0) begin
      bus.req0_op = op; bus.req0_a = DW'(a); bus.req0_b = DW'(b);
    end else begin
      bus.req1_op = op; bus.req1_a = DW'(a); bus.req1_b = DW'(b);
    end
    bus.req_valid = 2'(1 << r);
    #1;
    check("req_ready", 32'(bus.req_ready), 32'(1 << r));
    e.vld = 2'(1 << r);
    e.res = model(op, a, b);
    exp_q.push_back(e);
    tick();
    bus.req_valid = 2'b00;
    scramble();
    check("busy_exec", 32'(bus.busy), 1);
    check("ready_exec", 32'(bus.req_ready), 0);
    cyc = 0;
    while (bus.rsp_valid == 2'b00 && cyc < 8) begin
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 1);
    pop_check(got);
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        bus.rsp_ready = 2'(1 << (1 - r));
        bus.req_valid = 2'b11;
        scramble();
        tick();
        check("hold_valid", 32'(bus.rsp_valid), 32'(e.vld));
        check("hold_result", 32'(bus.rsp_result), 32'(e.res));
        check("hold_ready", 32'(bus.req_ready), 0);
      end
      bus.req_valid = 2'b00;
    end
    bus.rsp_ready = 2'(1 << r);
    tick();
    bus.rsp_ready = 2'b00;
    mcnt++;
    check("op_count", 32'(bus.op_count), 32'(8'(mcnt)));
    check("rsp_valid_clr", 32'(bus.rsp_valid), 0);
    check("busy_idle", 32'(bus.busy), 0);
  endtask

  // Continuous requests with rsp_ready high; scoreboard on every grant/response.
  task automatic run_stream(input logic [1:0] rv, input int n_done, input bit chk_seq);
    int         done;
    int         grants;
    int         cyc;
    logic       mlast;
    logic [1:0] eg;
    logic [1:0] seq [4];
    exp_t       e;
    exp_t       got;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    done = 0; grants = 0; cyc = 0;
    mlast = 1'b1;
    bus.req0_op = OP_ADD; bus.req0_a = 3'd1; bus.req0_b = 3'd2;
    bus.req1_op = OP_XOR; bus.req1_a = 3'd5; bus.req1_b = 3'd3;
    bus.req_valid = rv;
    bus.rsp_ready = 2'b11;
    #1;
    while (done < n_done && cyc < 4 * n_done + 20) begin
      if (bus.rsp_valid != 2'b00) begin
        pop_check(got);
        done++;
        mcnt++;
        mlast = got.vld[1];
      end
      if (bus.req_ready != 2'b00) begin
        if (rv == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
          eg = mlast ? 2'b01 : 2'b10;
`else
          eg = 2'b01;
`endif
        end else begin
          eg = rv;
        end
        check("grant", 32'(bus.req_ready), 32'(eg));
        if (chk_seq && grants < 4) check("grant_seq", 32'(bus.req_ready), 32'(seq[grants]));
        grants++;
        e.vld = bus.req_ready;
        e.res = bus.req_ready[1] ? model(OP_XOR, 5, 3) : model(OP_ADD, 1, 2);
        exp_q.push_back(e);
      end
      tick();
      cyc++;
    end
    check("stream_done", 32'(done), 32'(n_done));
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    do_reset();
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_result", 32'(bus.rsp_result), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_op_count", 32'(bus.op_count), 0);

    do_op(0, OP_ADD, 5, 4, 1'b0);
    do_op(1, OP_SUB, 2, 5, 1'b0);
    do_op(0, OP_XOR, 6, 3, 1'b0);
    do_op(1, OP_SHL, 7, 0, 1'b1);
    do_op(0, OP_ADD, 7, 7, 1'b0);
    do_op(1, OP_SUB, 0, 7, 1'b0);
    do_op(0, OP_SHL, 7, 0, 1'b0);

    // Reset asserted while an operation sits in EXEC.
    bus.req1_op = OP_ADD; bus.req1_a = 3'd3; bus.req1_b = 3'd3;
    bus.req_valid = 2'b10;
    #1;
    check("pre_rst_ready", 32'(bus.req_ready), 32'(2'b10));
    tick();
    check("pre_rst_busy", 32'(bus.busy), 1);
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    check("rst_exec_busy", 32'(bus.busy), 0);
    check("rst_exec_valid", 32'(bus.rsp_valid), 0);
    check("rst_exec_result", 32'(bus.rsp_result), 0);
    check("rst_exec_count", 32'(bus.op_count), 0);
    check("rst_exec_ready", 32'(bus.req_ready), 0);
    repeat (2) tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    rst_n = 1'b1;
    mcnt = 0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_stale_valid", 32'(bus.rsp_valid), 0);
      check("no_stale_busy", 32'(bus.busy), 0);
    end
    bus.rsp_ready = 2'b00;

    // Arbitration with both requesters continuously valid.
    do_reset();
    run_stream(2'b11, 6, 1'b1);
    check("arb_op_count", 32'(bus.op_count), 32'(8'(mcnt)));

    // op_count wrap after 256 completions.
    do_reset();
    run_stream(2'b01, 255, 1'b0);
    check("count_255", 32'(bus.op_count), 32'd255);
    run_stream(2'b01, 1, 1'b0);
    check("count_wrap", 32'(bus.op_count), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
